// File: rtl/bram_block_streamer_if.sv
// Handshake bundle between the block streamer, its BRAM read port and the
// downstream big-number consumer. The streamer binds to the master modport.
interface bram_block_streamer_if #(
  parameter int unsigned REGISTER_SIZE = 32
);
  logic                     start_in;
  logic                     busy_out;
  logic                     done_out;
  logic                     read_req_out;
  logic [REGISTER_SIZE-1:0] read_data_in;
  logic                     read_valid_in;
  logic [REGISTER_SIZE-1:0] data_out;
  logic                     valid_out;
  logic                     last_out;
  logic                     ready_in;
  logic                     overflow_out;

  modport master (
    input  start_in,
    input  read_data_in,
    input  read_valid_in,
    input  ready_in,
    output busy_out,
    output done_out,
    output read_req_out,
    output data_out,
    output valid_out,
    output last_out,
    output overflow_out
  );

  modport slave (
    output start_in,
    output read_data_in,
    output read_valid_in,
    output ready_in,
    input  busy_out,
    input  done_out,
    input  read_req_out,
    input  data_out,
    input  valid_out,
    input  last_out,
    input  overflow_out
  );
endinterface

// File: rtl/bram_block_streamer.sv
// Streams one big number out of the block BRAM, LSB block first. Read pulses are
// throttled so that blocks already in flight plus blocks buffered never exceed the
// FIFO, which absorbs the fixed 2-cycle BRAM read latency without losing throughput.
module bram_block_streamer #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned NUM_BLOCKS    = 128,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input logic                   clk_in,
  input logic                   rst_in,
  bram_block_streamer_if.master bus
);

  localparam int unsigned CntW = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // inflight <= 2 < FIFO_DEPTH, so one extra bit covers occupancy + inflight
  localparam int unsigned SumW = OccW + 1;

  localparam logic [CntW-1:0] NumBlocksC = CntW'(NUM_BLOCKS);
  localparam logic [CntW-1:0] LastIdxC   = CntW'(NUM_BLOCKS - 1);
  localparam logic [OccW-1:0] DepthC     = OccW'(FIFO_DEPTH);
  localparam logic [SumW-1:0] DepthSumC  = SumW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrMaxC    = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          issued_q, issued_d;
  logic [CntW-1:0]          emitted_q, emitted_d;
  logic [1:0]               inflight_q, inflight_d;
  logic [OccW-1:0]          occ_q, occ_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                     overflow_q, overflow_d;
  logic [REGISTER_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic read_req;
  logic fifo_full;
  logic push_ok;
  logic pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMaxC) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake decode: issue gating, FIFO push/pop qualifiers
  always_comb begin
    fifo_full = (occ_q == DepthC);
    read_req  = (state_q == StRun) && (issued_q < NumBlocksC) &&
                ((SumW'(occ_q) + SumW'(inflight_q)) < DepthSumC);
    push_ok   = bus.read_valid_in && !fifo_full;
    pop       = (occ_q != '0) && bus.ready_in;
  end

  // FSM next state and run counters; counters clear on the way back to idle
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    emitted_d = emitted_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_in) state_d = StRun;
      end
      StRun: begin
        issued_d  = issued_q + CntW'(read_req);
        emitted_d = emitted_q + CntW'(pop);
        if (emitted_d == NumBlocksC) state_d = StDone;
      end
      StDone: begin
        state_d   = StIdle;
        issued_d  = '0;
        emitted_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO is dropped and flagged sticky
  always_comb begin
    inflight_d = inflight_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (read_req && !bus.read_valid_in) begin
      inflight_d = inflight_q + 2'd1;
    end else if (!read_req && bus.read_valid_in && (inflight_q != '0)) begin
      inflight_d = inflight_q - 2'd1;
    end
    if (bus.read_valid_in && fifo_full) overflow_d = 1'b1;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_ok && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (!push_ok && pop) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      issued_q   <= '0;
      emitted_q  <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage, written on the same edge that read_valid_in is seen
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.read_data_in;
    end
  end

  // Outputs; data_out is forced to zero while the FIFO is empty
  always_comb begin
    bus.busy_out     = (state_q == StRun);
    bus.done_out     = (state_q == StDone);
    bus.read_req_out = read_req;
    bus.valid_out    = (occ_q != '0);
    bus.data_out     = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    bus.last_out     = (occ_q != '0) && (emitted_q == LastIdxC);
    bus.overflow_out = overflow_q;
  end

endmodule

// File: tb/tb_bram_block_streamer.sv
// Bench for bram_block_streamer: a BRAM read-port model with 2-cycle latency feeds
// the DUT; a transaction-level model (request/handshake counts, run phase) is
// compared against the DUT every cycle, plus directed latency/count expectations.
module tb_bram_block_streamer;
  localparam int unsigned RS = 32;
  localparam int unsigned NB = 128;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_block_streamer_if #(.REGISTER_SIZE(RS)) bus ();

  bram_block_streamer #(
    .REGISTER_SIZE(RS),
    .NUM_BLOCKS   (NB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  // BRAM read-port model: word i = i, address wraps, same reset domain
  logic [RS-1:0] bram_mem [NB];
  int unsigned   bram_addr;
  logic          v1, v2;
  logic [RS-1:0] d1, d2;
  logic          rnd_en;
  logic          rnd_valid;
  logic [RS-1:0] rnd_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr <= 0;
      v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v1 <= bus.read_req_out;
      d1 <= bram_mem[bram_addr];
      if (bus.read_req_out) bram_addr <= (bram_addr + 1) % NB;
      v2 <= v1;
      d2 <= d1;
    end
  end
  assign bus.read_valid_in = rnd_en ? rnd_valid : v2;
  assign bus.read_data_in  = rnd_en ? rnd_data : d2;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready

  // Transaction-level model state
  int          phase;      // 0 idle, 1 run, 2 done
  int          req_cnt, pop_cnt, arrived;
  logic [2:0]  hist;
  logic        prev_stall, prev_last;
  logic [RS-1:0] prev_data;
  // DUT-side recordings for directed checks
  int          dut_req_cnt, dut_done_cnt, run_last, last_cnt;
  int unsigned first_valid_cyc, last_hs_cyc, done_cyc;
  logic [RS-1:0] first_data;
  logic        seen_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    req_cnt = 0; pop_cnt = 0; arrived = 0; hist = '0;
    prev_stall = 1'b0; seen_valid = 1'b0; last_cnt = 0;
  endtask

  task automatic model_step();
    logic exp_busy, exp_done, exp_valid, exp_req, hs;
    if (!rst_n) begin
      phase = 0;
      model_clear();
      return;
    end
    if (hist[2]) arrived++;
    exp_busy  = (phase == 1);
    exp_done  = (phase == 2);
    exp_valid = (arrived > pop_cnt);
    exp_req   = (phase == 1) && (req_cnt < NB) && ((req_cnt - pop_cnt) < FD);
    check("busy_out", 32'(bus.busy_out), 32'(exp_busy));
    check("done_out", 32'(bus.done_out), 32'(exp_done));
    check("read_req_out", 32'(bus.read_req_out), 32'(exp_req));
    check("valid_out", 32'(bus.valid_out), 32'(exp_valid));
    check("overflow_out", 32'(bus.overflow_out), 32'd0);
    if (exp_valid) begin
      check("data_out", bus.data_out, (pop_cnt < NB) ? bram_mem[pop_cnt] : '0);
      check("last_out", 32'(bus.last_out), 32'(pop_cnt == NB - 1));
      if (prev_stall) begin
        check("data_hold", bus.data_out, prev_data);
        check("last_hold", 32'(bus.last_out), 32'(prev_last));
      end
    end else begin
      check("last_unqualified", 32'(bus.last_out), 32'd0);
    end
    if (bus.valid_out && !seen_valid) begin
      seen_valid = 1'b1;
      first_valid_cyc = cyc;
      first_data = bus.data_out;
    end
    if (bus.read_req_out) dut_req_cnt++;
    if (bus.valid_out && bus.ready_in && bus.last_out) begin
      last_hs_cyc = cyc;
      last_cnt++;
    end
    if (bus.done_out) begin
      dut_done_cnt++;
      done_cyc = cyc;
    end
    hs = exp_valid && bus.ready_in;
    prev_stall = exp_valid && !bus.ready_in;
    prev_data  = bus.data_out;
    prev_last  = bus.last_out;
    hist = {hist[1:0], exp_req};
    if (exp_req) req_cnt++;
    if (hs) pop_cnt++;
    case (phase)
      0: if (bus.start_in) phase = 1;
      1: if (pop_cnt == NB) phase = 2;
      default: begin
        run_last = last_cnt;
        model_clear();
        phase = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: bus.ready_in = 1'b1;
      1: bus.ready_in = 1'($urandom_range(0, 1));
      default: bus.ready_in = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int budget);
    int d0 = dut_done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dut_done_cnt != d0) break;
    end
    check("done_within_budget", 32'(dut_done_cnt != d0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
    check({tag, "_done"}, 32'(bus.done_out), 32'd0);
    check({tag, "_req"}, 32'(bus.read_req_out), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_last"}, 32'(bus.last_out), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow_out), 32'd0);
    check({tag, "_data"}, bus.data_out, 32'd0);
  endtask

  int unsigned s;

  initial begin
    for (int i = 0; i < int'(NB); i++) bram_mem[i] = RS'(i);
    bus.start_in = 1'b0;
    bus.ready_in = 1'b1;
    rnd_en = 1'b1; rnd_valid = 1'b0; rnd_data = '0;
    phase = 0; model_clear();
    dut_req_cnt = 0; dut_done_cnt = 0; run_last = 0;
    first_valid_cyc = 0; last_hs_cyc = 0; done_cyc = 0; first_data = '0;

    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.start_in = 1'($urandom_range(0, 1));
      bus.ready_in = 1'($urandom_range(0, 1));
      rnd_valid = 1'($urandom_range(0, 1));
      rnd_data = $urandom;
      #2;
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    rnd_en = 1'b0; bus.start_in = 1'b0; bus.ready_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dut_req_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_no_req", 32'(dut_req_cnt), 32'd0);

    // 2: full-rate run
    ready_mode = 0;
    tick();
    dut_req_cnt = 0;
    s = cyc;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    wait_done(300);
    check("t2_first_valid_lat", first_valid_cyc - s, 32'd4);
    check("t2_first_data", first_data, 32'd0);
    check("t2_last_hs_cyc", last_hs_cyc - s, 32'd131);
    check("t2_done_cyc", done_cyc - s, 32'd132);
    check("t2_req_count", 32'(dut_req_cnt), 32'd128);
    check("t2_last_count", 32'(run_last), 32'd1);

    // 3: random backpressure
    ready_mode = 1;
    tick();
    dut_req_cnt = 0;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    wait_done(2000);
    check("t3_req_count", 32'(dut_req_cnt), 32'd128);
    check("t3_last_count", 32'(run_last), 32'd1);
    check("t3_overflow", 32'(bus.overflow_out), 32'd0);

    // 4: no ready at all after start
    ready_mode = 2;
    tick();
    dut_req_cnt = 0;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t4_req_count", 32'(dut_req_cnt), 32'd4);
    check("t4_valid_held", 32'(bus.valid_out), 32'd1);
    check("t4_data_held", bus.data_out, 32'd0);
    ready_mode = 0;
    wait_done(300);
    check("t4_req_total", 32'(dut_req_cnt), 32'd128);

    // 5: starts during a run are ignored; second run wraps back to block 0
    ready_mode = 0;
    tick();
    s = dut_done_cnt;
    bus.start_in = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      bus.start_in = (k == 10 || k == 60);
    end
    bus.start_in = 1'b0;
    check("t5_one_done", 32'(dut_done_cnt - int'(s)), 32'd1);
    tick();
    check("t5_idle_busy", 32'(bus.busy_out), 32'd0);
    dut_req_cnt = 0;
    s = cyc;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    wait_done(300);
    check("t5_rerun_first_data", first_data, 32'd0);
    check("t5_rerun_req_count", 32'(dut_req_cnt), 32'd128);
    check("t5_rerun_done_cyc", done_cyc - s, 32'd132);

    // 6: reset mid-run, then a fresh run starts at block 0
    tick();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    rst_n = 1'b0;
    #2;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    s = cyc;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    wait_done(300);
    check("t6_first_valid_lat", first_valid_cyc - s, 32'd4);
    check("t6_first_data", first_data, 32'd0);
    check("t6_done_cyc", done_cyc - s, 32'd132);

    for (int i = 0; i < 3; i++) tick();
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
